// File: rtl/mips_cpu_lsu_pkg.sv
// Shared types and helpers for the MIPS load/store unit.
//   lsu_op_t          : request operation codes as seen on req_op
//   lsu_state_t       : control FSM states
//   DATA_BASE_DEFAULT : byte address of data word 0
//   is_store/is_legal : operation classification helpers
package mips_cpu_lsu_pkg;

    localparam logic [31:0] DATA_BASE_DEFAULT  = 32'h0000_1000;
    localparam int unsigned DATA_WORDS_DEFAULT = 32;

    typedef enum logic [3:0] {
        OpLw  = 4'd0,
        OpLh  = 4'd1,
        OpLhu = 4'd2,
        OpLb  = 4'd3,
        OpLbu = 4'd4,
        OpLwl = 4'd5,
        OpLwr = 4'd6,
        OpSw  = 4'd8,
        OpSh  = 4'd9,
        OpSb  = 4'd10
    } lsu_op_t;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StStore,
        StRmwRd,
        StRmwWr,
        StResp
    } lsu_state_t;

    function automatic logic is_store(input logic [3:0] op);
        return (op == OpSw) || (op == OpSh) || (op == OpSb);
    endfunction

    function automatic logic is_legal(input logic [3:0] op);
        return (op <= 4'd6) || is_store(op);
    endfunction

    // Ops that must be word aligned.
    function automatic logic needs_word_align(input logic [3:0] op);
        return (op == OpLw) || (op == OpSw);
    endfunction

    // Ops that must be halfword aligned.
    function automatic logic needs_half_align(input logic [3:0] op);
        return (op == OpLh) || (op == OpLhu) || (op == OpSh);
    endfunction

endpackage

// File: rtl/mips_cpu_lsu_align.sv
// Combinational lane logic for the load/store unit (big-endian lanes).
//   op          in  4   latched operation code
//   offset      in  2   byte offset within the word (addr[1:0])
//   mem         in  32  memory word (read data for loads, merge word for stores)
//   rt_old      in  32  previous rt value, merged by LWL/LWR
//   wdata       in  32  store data
//   load_result out 32  extracted / extended / merged load value
//   store_word  out 32  memory word with the target lane replaced
module mips_cpu_lsu_align
    import mips_cpu_lsu_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [1:0]  offset,
    input  logic [31:0] mem,
    input  logic [31:0] rt_old,
    input  logic [31:0] wdata,
    output logic [31:0] load_result,
    output logic [31:0] store_word
);

    logic [4:0]  shl_amt;
    logic [4:0]  shr_amt;
    logic [31:0] mem_shr;
    logic [31:0] byte_lane_mask;
    logic [7:0]  byte_val;
    logic [15:0] half_val;

    always_comb begin
        // Byte k lives at [31-8k -: 8], so 8*(3-k) brings it down to bit 0.
        shl_amt        = {offset, 3'b000};
        shr_amt        = {~offset, 3'b000};
        mem_shr        = mem >> shr_amt;
        byte_val       = mem_shr[7:0];
        half_val       = offset[1] ? mem[15:0] : mem[31:16];
        byte_lane_mask = 32'h0000_00FF << shr_amt;

        load_result = mem;
        case (op)
            OpLb:    load_result = {{24{byte_val[7]}}, byte_val};
            OpLbu:   load_result = {24'd0, byte_val};
            OpLh:    load_result = {{16{half_val[15]}}, half_val};
            OpLhu:   load_result = {16'd0, half_val};
            OpLwl:   load_result = (mem << shl_amt) | (rt_old & ((32'd1 << shl_amt) - 32'd1));
            OpLwr:   load_result = mem_shr | (rt_old & ~(32'hFFFF_FFFF >> shr_amt));
            default: load_result = mem;
        endcase

        store_word = mem;
        case (op)
            OpSw:    store_word = wdata;
            OpSh:    store_word = offset[1] ? {mem[31:16], wdata[15:0]}
                                            : {wdata[15:0], mem[15:0]};
            OpSb:    store_word = (mem & ~byte_lane_mask) | ({24'd0, wdata[7:0]} << shr_amt);
            default: store_word = mem;
        endcase
    end

endmodule

// File: rtl/mips_cpu_load_store_unit.sv
// MIPS load/store unit between the memory stage and a word-wide data memory.
// Handles LW/LH/LHU/LB/LBU/LWL/LWR and SW/SH/SB; SH/SB use read-modify-write.
//   clk, reset_n                    clock, async active-low reset
//   req_valid/req_ready             request handshake (ready only when idle)
//   req_op/req_addr/req_wdata       operation, byte address, store data
//   req_rt_old                      old rt value for LWL/LWR
//   resp_valid/resp_rdata/resp_error one-cycle completion pulse with result
//   data_address/data_read/data_write/data_writedata/data_readdata  memory port
module mips_cpu_load_store_unit
    import mips_cpu_lsu_pkg::*;
#(
    parameter logic [31:0] DATA_BASE  = DATA_BASE_DEFAULT,
    parameter int unsigned DATA_WORDS = DATA_WORDS_DEFAULT
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [31:0] req_rt_old,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    output logic [31:0] data_address,
    output logic        data_read,
    output logic        data_write,
    output logic [31:0] data_writedata,
    input  logic [31:0] data_readdata
);

    // One past the last legal byte; 33 bits so the limit cannot wrap.
    localparam logic [32:0] DataLimit = {1'b0, DATA_BASE} + 33'(DATA_WORDS) * 33'd4;

    lsu_state_t  state_q, state_d;
    logic [3:0]  op_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rt_old_q;
    logic [31:0] merge_q, merge_d;
    logic [31:0] rdata_q, rdata_d;
    logic        error_q, error_d;

    logic        accept;
    logic        req_illegal;
    logic        req_out_of_range;
    logic        req_misaligned;
    logic        req_error;
    logic [31:0] align_mem;
    logic [31:0] load_result;
    logic [31:0] store_word;

    assign req_ready    = (state_q == StIdle);
    assign accept       = req_valid && req_ready;
    assign resp_valid   = (state_q == StResp);
    assign resp_rdata   = rdata_q;
    assign resp_error   = error_q;
    assign data_address = {addr_q[31:2], 2'b00};

    // Checked on the request as it is accepted, i.e. the values being latched.
    always_comb begin
        req_illegal      = !is_legal(req_op);
        req_out_of_range = (req_addr < DATA_BASE) || ({1'b0, req_addr} >= DataLimit);
        req_misaligned   = (needs_word_align(req_op) && (req_addr[1:0] != 2'b00)) ||
                           (needs_half_align(req_op) && req_addr[0]);
        req_error        = req_illegal || req_out_of_range || req_misaligned;
    end

    // Loads extract from the live read word; the RMW write merges into the saved word.
    assign align_mem = (state_q == StRmwWr) ? merge_q : data_readdata;

    mips_cpu_lsu_align u_align (
        .op          (op_q),
        .offset      (addr_q[1:0]),
        .mem         (align_mem),
        .rt_old      (rt_old_q),
        .wdata       (wdata_q),
        .load_result (load_result),
        .store_word  (store_word)
    );

    always_comb begin
        state_d        = state_q;
        merge_d        = merge_q;
        rdata_d        = rdata_q;
        error_d        = error_q;
        data_read      = 1'b0;
        data_write     = 1'b0;
        data_writedata = 32'd0;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (req_error) begin
                        state_d = StResp;
                        rdata_d = 32'd0;
                        error_d = 1'b1;
                    end else if (!is_store(req_op)) begin
                        state_d = StLoad;
                    end else if (req_op == OpSw) begin
                        state_d = StStore;
                    end else begin
                        state_d = StRmwRd;
                    end
                end
            end
            StLoad: begin
                data_read = 1'b1;
                rdata_d   = load_result;
                error_d   = 1'b0;
                state_d   = StResp;
            end
            StStore: begin
                data_write     = 1'b1;
                data_writedata = wdata_q;
                rdata_d        = 32'd0;
                error_d        = 1'b0;
                state_d        = StResp;
            end
            StRmwRd: begin
                data_read = 1'b1;
                merge_d   = data_readdata;
                state_d   = StRmwWr;
            end
            StRmwWr: begin
                data_write     = 1'b1;
                data_writedata = store_word;
                rdata_d        = 32'd0;
                error_d        = 1'b0;
                state_d        = StResp;
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            op_q     <= 4'd0;
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
            rt_old_q <= 32'd0;
            merge_q  <= 32'd0;
            rdata_q  <= 32'd0;
            error_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            merge_q <= merge_d;
            rdata_q <= rdata_d;
            error_q <= error_d;
            if (accept) begin
                op_q     <= req_op;
                addr_q   <= req_addr;
                wdata_q  <= req_wdata;
                rt_old_q <= req_rt_old;
            end
        end
    end

endmodule
